// File: rtl/mod4_pair_tx.sv
// Two-lane serialiser: one WIDTH-bit word out as WIDTH/2 bit pairs (LSB pair first); optional trailing parity pair via MOD4_PAIR_TX_PARITY_PAIR_EN.
// Latency: word accepted on edge N shows pair 0 after edge N; pair k after edge N+k.
// Backpressure: ready is low for the whole frame; nothing is queued, so frames are separated by at least one idle 00 cycle.
module mod4_pair_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             out_1,
    output logic             out_2,
    output logic             out_valid,
    output logic             out_last
);
    localparam int PAIRS = WIDTH / 2;
    localparam int CW    = $clog2(PAIRS) + 1;
    localparam logic [CW-1:0] LAST_K = CW'(PAIRS - 1);
`ifdef MOD4_PAIR_TX_PARITY_PAIR_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SHIFT
`ifdef MOD4_PAIR_TX_PARITY_PAIR_EN
        ,
        PAR
`endif
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
`ifdef MOD4_PAIR_TX_PARITY_PAIR_EN
    logic             parity;
`endif

    assign ready_o = (state == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            out_1     <= 1'b0;
            out_2     <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
`ifdef MOD4_PAIR_TX_PARITY_PAIR_EN
            parity    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    out_1     <= 1'b0;
                    out_2     <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    if (valid_i) begin
                        // Pair 0 goes straight to the output register; the
                        // shift register keeps only the pairs still to send.
                        shreg     <= data_i >> 2;
                        out_1     <= data_i[0];
                        out_2     <= data_i[1];
                        out_valid <= 1'b1;
                        out_last  <= !PAR_EN && (LAST_K == '0);
                        cnt       <= '0;
                        state     <= SHIFT;
`ifdef MOD4_PAIR_TX_PARITY_PAIR_EN
                        parity    <= ^data_i;
`endif
                    end
                end
                SHIFT: begin
                    if (cnt == LAST_K) begin
`ifdef MOD4_PAIR_TX_PARITY_PAIR_EN
                        out_1     <= 1'b0;
                        out_2     <= parity;
                        out_valid <= 1'b1;
                        out_last  <= 1'b1;
                        state     <= PAR;
`else
                        out_1     <= 1'b0;
                        out_2     <= 1'b0;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= IDLE;
`endif
                    end else begin
                        cnt      <= cnt + CW'(1);
                        out_1    <= shreg[0];
                        out_2    <= shreg[1];
                        shreg    <= shreg >> 2;
                        out_last <= !PAR_EN && ((cnt + CW'(1)) == LAST_K);
                    end
                end
`ifdef MOD4_PAIR_TX_PARITY_PAIR_EN
                PAR: begin
                    out_1     <= 1'b0;
                    out_2     <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    state     <= IDLE;
                end
`endif
                default: begin
                    out_1     <= 1'b0;
                    out_2     <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mod4_pair_tx.sv
// Bench for mod4_pair_tx: expected pair streams are derived from the data word bit by bit.
module tb_mod4_pair_tx;
    localparam int W = 8;
    localparam int P = W / 2;
`ifdef MOD4_PAIR_TX_PARITY_PAIR_EN
    localparam int F = P + 1;
`else
    localparam int F = P;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] data_i = '0;
    logic         valid_i = 1'b0;
    logic         ready_o, out_1, out_2, out_valid, out_last;

    int checks = 0;
    int errors = 0;

    bit exp_1[$], exp_2[$], exp_last[$];
    bit obs_1[$], obs_2[$], obs_last[$], obs_rdy[$];

    mod4_pair_tx #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .out_1(out_1), .out_2(out_2), .out_valid(out_valid), .out_last(out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic void build_expected(input logic [W-1:0] d);
        exp_1.delete(); exp_2.delete(); exp_last.delete();
        for (int k = 0; k < P; k++) begin
            exp_1.push_back(d[2*k]);
            exp_2.push_back(d[2*k+1]);
            exp_last.push_back(1'b0);
        end
`ifdef MOD4_PAIR_TX_PARITY_PAIR_EN
        exp_1.push_back(1'b0);
        exp_2.push_back(^d);
        exp_last.push_back(1'b0);
`endif
        exp_last[exp_last.size()-1] = 1'b1;
    endfunction

    // Pulse valid for one cycle from a negedge where the DUT is idle.
    task automatic send(input logic [W-1:0] d);
        valid_i = 1'b1;
        data_i  = d;
        @(negedge clk);
        valid_i = 1'b0;
        data_i  = W'($urandom);
    endtask

    // Record the frame that is (or is about to be) on the outputs; ok=0 on timeout.
    task automatic capture(output bit ok);
        bit started = 1'b0;
        ok = 1'b0;
        obs_1.delete(); obs_2.delete(); obs_last.delete(); obs_rdy.delete();
        for (int g = 0; g < 40; g++) begin
            if (out_valid) begin
                started = 1'b1;
                obs_1.push_back(out_1);
                obs_2.push_back(out_2);
                obs_last.push_back(out_last);
                obs_rdy.push_back(ready_o);
            end else if (started) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; valid_i = 1'b1; data_i = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, out_1, out_2, out_last, ready_o} !== 5'b00001) begin
                errors++;
                $display("FAIL reset cycle %0d: v/o1/o2/last/rdy=%b required 00001", c,
                         {out_valid, out_1, out_2, out_last, ready_o});
            end
        end
        valid_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, ready_o} !== 2'b01) begin
            errors++;
            $display("FAIL reset release: v/rdy=%b required 01", {out_valid, ready_o});
        end
    endtask

    task automatic test_frame(input logic [W-1:0] d, input string name);
        bit ok;
        build_expected(d);
        send(d);
        capture(ok);
        checks++;
        if (!ok || obs_1.size() != exp_1.size()) begin
            errors++;
            $display("FAIL %s length: ok=%0d got %0d pairs required %0d", name, ok, obs_1.size(), exp_1.size());
        end
        for (int i = 0; i < exp_1.size() && i < obs_1.size(); i++) begin
            checks++;
            if ({obs_1[i], obs_2[i], obs_last[i], obs_rdy[i]} !== {exp_1[i], exp_2[i], exp_last[i], 1'b0}) begin
                errors++;
                $display("FAIL %s pair %0d: o1/o2/last/rdy=%b required %b", name, i,
                         {obs_1[i], obs_2[i], obs_last[i], obs_rdy[i]}, {exp_1[i], exp_2[i], exp_last[i], 1'b0});
            end
        end
        checks++;
        if ({out_valid, out_1, out_2, ready_o} !== 4'b0001) begin
            errors++;
            $display("FAIL %s trailing idle: v/o1/o2/rdy=%b required 0001", name, {out_valid, out_1, out_2, ready_o});
        end
    endtask

    task automatic test_single;
        test_frame(8'hB4, "single_b4");
    endtask

`ifdef MOD4_PAIR_TX_PARITY_PAIR_EN
    task automatic test_parity;
        test_frame(8'h07, "parity_07");
        checks++;
        if (obs_1.size() != 5 || {obs_1[4], obs_2[4], obs_last[4]} !== 3'b011) begin
            errors++;
            $display("FAIL parity_07 par pair: size=%0d required 5 with pair 0,1 last", obs_1.size());
        end
        test_frame(8'hB4, "parity_b4");
    endtask
`endif

    task automatic test_back_to_back;
        bit s_v[$], s_1[$], s_2[$];
        bit e_v[$], e_1[$], e_2[$];
        build_expected(8'h01);
        foreach (exp_1[i]) begin e_v.push_back(1); e_1.push_back(exp_1[i]); e_2.push_back(exp_2[i]); end
        e_v.push_back(0); e_1.push_back(0); e_2.push_back(0);
        build_expected(8'h80);
        foreach (exp_1[i]) begin e_v.push_back(1); e_1.push_back(exp_1[i]); e_2.push_back(exp_2[i]); end
        e_v.push_back(0); e_1.push_back(0); e_2.push_back(0);

        valid_i = 1'b1; data_i = 8'h01;
        @(negedge clk);
        data_i = 8'h80;
        for (int i = 0; i < 2*F + 2; i++) begin
            s_v.push_back(out_valid); s_1.push_back(out_1); s_2.push_back(out_2);
            if (i == F) begin
                checks++;
                if (ready_o !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b gap ready: got %b required 1", ready_o);
                end
            end
            if (i == F + 1) valid_i = 1'b0;
            @(negedge clk);
        end
        for (int i = 0; i < e_v.size(); i++) begin
            checks++;
            if ({s_v[i], s_1[i], s_2[i]} !== {e_v[i], e_1[i], e_2[i]}) begin
                errors++;
                $display("FAIL b2b cycle %0d: v/o1/o2=%b required %b", i, {s_v[i], s_1[i], s_2[i]}, {e_v[i], e_1[i], e_2[i]});
            end
        end
    endtask

    task automatic test_mid_reset;
        int stray = 0;
        send(8'hB4);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_1, out_2, out_last, ready_o} !== 5'b00001) begin
            errors++;
            $display("FAIL mid_reset async: v/o1/o2/last/rdy=%b required 00001",
                     {out_valid, out_1, out_2, out_last, ready_o});
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 2*F; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || ready_o !== 1'b1) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL mid_reset residual: %0d non-idle cycles required 0", stray);
        end
    endtask

    task automatic test_loopback;
        test_frame(8'h0F, "loopback_0f");
        checks++;
        if (obs_1.size() < 4 || {obs_1[0], obs_2[0], obs_1[1], obs_2[1], obs_1[2], obs_2[2], obs_1[3], obs_2[3]} !== 8'b11110000) begin
            errors++;
            $display("FAIL loopback_0f pairs: size=%0d required pairs 11,11,00,00", obs_1.size());
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 25; n++) begin
            int gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            test_frame(W'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_single();
`ifdef MOD4_PAIR_TX_PARITY_PAIR_EN
        test_parity();
`endif
        test_back_to_back();
        test_mid_reset();
        test_loopback();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mod4_pair_tx.md
Name: mod4_pair_tx

Overview:
- Dual-lane serial transmitter: accepts a parallel WIDTH-bit word through a valid/ready handshake and shifts it out two bits per clock on out_1/out_2, LSB pair first.
- It is the source side of the two-bit-per-cycle stream consumed by the team's mod-4 stream checker; out_1/out_2 connect directly to the checker's in_1/in_2.
- Provides frame-valid and last-pair strobes so a bench or downstream logic can align frames.

Parameters:
- WIDTH, 8, data word width in bits; must be even and >= 2 (WIDTH/2 pair cycles per frame).

Ports:
- clk  input  1  clock, rising-edge active.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
- data_i  input  WIDTH  word to transmit; sampled only on the accepting handshake edge.
- valid_i  input  1  data_i valid request.
- ready_o  output  1  block can accept a word this cycle.
- out_1  output  1  lane 1 serial bit (even data bit of current pair).
- out_2  output  1  lane 2 serial bit (odd data bit of current pair).
- out_valid  output  1  out_1/out_2 carry a frame pair this cycle.
- out_last  output  1  current pair is the final pair of the frame.

Behaviour:
- Reset (rst=0): state=IDLE, shift register=0, pair counter=0, out_1=out_2=0, out_valid=0, out_last=0, ready_o=1. Applies asynchronously.
- Reset mid-frame aborts the frame: no further pairs are sent, and the word is lost.
- All outputs are registered except ready_o, which decodes state (ready_o=1 iff state==IDLE).
- FSM states:
  - IDLE: out_valid=0, out_1=out_2=0. On a clk edge with valid_i=1, load data_i into the shift register, clear the pair counter, and go to SHIFT.
  - SHIFT: out_valid=1. In pair cycle k (k=0..WIDTH/2-1), out_1=data[2k] and out_2=data[2k+1]. After the k=WIDTH/2-1 cycle, go to IDLE, or to PAR when PARITY_PAIR_EN is defined.
  - PAR: exists only when PARITY_PAIR_EN is defined. One cycle, then IDLE.
- Latency: handshake accepted on edge N; pair 0 is visible after edge N, pair WIDTH/2-1 after edge N+WIDTH/2-1.
- Back-to-back words: ready_o is low for the whole frame, so there is at least one idle cycle (out_valid=0, outputs 00) between frames.
- out_last=1 only during the final frame cycle: the last data pair, or the PAR cycle when that state is enabled.
- valid_i or data_i changes while not ready are ignored; no word is queued.
- The counter is sized $clog2(WIDTH/2)+1 bits and has no wrap-around within a frame. It resets to 0 on each accept.
- Idle-encoding rule: the 00 idle pair leaves a downstream mod-4 checker's state unchanged.

Optional Feature:
- Macro: MOD4_PAIR_TX_PARITY_PAIR_EN.
- Defined: after the data pairs, one extra PAR cycle drives out_1=0 and out_2=p, where p = XOR of all WIDTH data bits. This makes the total count of ones in the frame even. out_valid=1 and out_last=1 during PAR, and the frame length is WIDTH/2+1 cycles.
- Undefined: no PAR state, the frame is exactly WIDTH/2 cycles, and out_last marks the last data pair.

Test Plan:
- Reset: hold rst=0 for 3 cycles with valid_i=1 and data_i=8'hFF -> out_valid=0, out_1=out_2=0, ready_o=1 throughout. No frame starts until rst=1.
- Single frame, data_i=8'hB4, valid_i pulsed 1 cycle:
  - out_1 sequence = 0,1,1,0 and out_2 sequence = 0,0,1,1.
  - out_valid=1 for 4 cycles, out_last=1 on the 4th, ready_o=0 for those 4 cycles.
- Parity pair (macro defined), data_i=8'h07 -> pairs (1,1),(1,0),(0,0),(0,0), then PAR pair (0,1) with out_last=1. With data_i=8'hB4, the PAR pair is (0,0).
- Back-to-back: valid_i held 1 with data 8'h01 then 8'h80 -> frame 1, exactly one cycle of out_valid=0, then frame 2 with out_1=0,0,0,0 and out_2=0,0,0,1. The second word is accepted on the IDLE edge only.
- Mid-frame reset: assert rst=0 during pair 2 of 8'hB4 -> outputs go to 0 immediately, without waiting for clk. After release, ready_o=1 and no residual pairs are emitted.
- Loopback: connect out_1/out_2 to the mod-4 checker, send 8'h0F -> the checker output matches its golden model for pairs (1,1),(1,1),(0,0),(0,0).
